truth_table_checker: RTL and testbench

- Synthesizable hardware checker for small combinational blocks, e.g. the and/not gate chain that forms a NAND.
- Sweeps every input combination onto a device under test (DUT), waits a programmable settle time, samples the DUT's 1-bit response and compares it with a golden truth table.
- Counts mismatches and reports pass/fail.
- Sits beside a gate-level DUT in lab top-levels, so checking runs in hardware or simulation without a procedural bench.

---
 rtl/truth_table_checker.sv | 170 +++++++++++++++++
 tb/tb_truth_table_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
//
// Exhaustive truth-table checker for a small combinational DUT. It drives
// every input combination onto stim in ascending order. Each vector is held
// for SETTLE cycles, then the 1-bit DUT response is sampled and compared
// against the golden table TRUTH. The checker counts mismatches and reports
// pass/fail once the sweep ends.
//
// Optional build macro: TRUTH_TABLE_CHECKER_STOP_ON_ERR_EN
//   When defined, the first mismatch ends the sweep immediately. stim then
//   keeps the failing vector so it can be inspected on the DUT.
//   When undefined, the full sweep always runs.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   start          in   sweep request, honoured only in IDLE or FIN
//   stim           out  [N_IN]    DUT input vector
//   dut_r          in   DUT response
//   busy           out  sweep in progress
//   done           out  sweep finished (held until next start or reset)
//   pass           out  done with zero mismatches
//   err_count      out  [N_IN+1]  mismatching vectors, saturates at 2**N_IN
//   first_err_vec  out  [N_IN]    stim of first mismatch (valid if err_count!=0)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_WAIT  | holding stim for the settle time (SETTLE cycles)
// S_CHECK | sampling dut_r against TRUTH[stim] (one cycle)
// S_FIN   | results held, start re-arms a fresh sweep

module truth_table_checker #(
  parameter int                      N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b0111,
  parameter int                      SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_r,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int ERR_W = N_IN + 1;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(1 << N_IN);
  localparam logic [N_IN-1:0]  LAST_VEC  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            state_q, state_n;
  logic [N_IN-1:0]   stim_q, stim_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [ERR_W-1:0]  err_q, err_n;
  logic [N_IN-1:0]   first_q, first_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  logic              expected;
  logic              mismatch;

  assign expected = TRUTH[stim_q];
  // Case inequality so that an X or Z response counts as a mismatch.
  assign mismatch = (dut_r !== expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      stim_q  <= stim_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      first_q <= first_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    stim_n  = stim_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    first_n = first_q;
    busy_n  = busy_q;
    done_n  = done_q;

    case (state_q)
      // IDLE and FIN share the same launch behaviour. All results are
      // cleared on the accepting edge.
      S_IDLE, S_FIN: begin
        if (start) begin
          state_n = S_WAIT;
          stim_n  = '0;
          cnt_n   = SETTLE_LD;
          err_n   = '0;
          first_n = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          if (err_q == '0) begin
            first_n = stim_q;
          end
          if (err_q != ERR_MAX) begin
            err_n = err_q + 1'b1;
          end
        end

`ifdef TRUTH_TABLE_CHECKER_STOP_ON_ERR_EN
        if (mismatch || (stim_q == LAST_VEC)) begin
`else
        if (stim_q == LAST_VEC) begin
`endif
          // stim is left on the last (or failing) vector.
          state_n = S_FIN;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = S_WAIT;
          stim_n  = stim_q + 1'b1;
          cnt_n   = SETTLE_LD;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_q;
  assign first_err_vec = first_q;
  assign pass          = done_q && (err_q == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam logic [3:0] GOLD0 = 4'b0111;       // NAND, N_IN=2
  localparam logic [7:0] GOLD1 = 8'b1001_0110;  // XOR3, N_IN=3
  localparam int S0 = 1;
  localparam int S1 = 3;

`ifdef TRUTH_TABLE_CHECKER_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start0, start1, r0, r1;
  logic [1:0] stim0, fe0;
  logic [2:0] stim1, fe1;
  logic [2:0] err0;
  logic [3:0] err1;
  logic       busy0, done0, pass0, busy1, done1, pass1;

  int   sel, mode, rtab;
  logic start_q;
  int   nvec, nerr;

  int   o_stim, o_err, o_fe;
  logic o_busy, o_done, o_pass;

  // DUT response models: mode 0 correct gate, 1 tied high, 2 inverted,
  // 3 arbitrary table in tab.
  function automatic logic resp(input int inst, input int m, input int k, input int tab);
    logic [2:0] b;
    b = k[2:0];
    case (m)
      0:       return (inst == 0) ? ~(b[1] & b[0]) : ^b;
      1:       return 1'b1;
      2:       return (inst == 0) ? (b[1] & b[0]) : ~^b;
      default: return tab[k];
    endcase
  endfunction

  always_comb begin
    start0 = start_q && (sel == 0);
    start1 = start_q && (sel == 1);
    r0     = resp(0, mode, int'(stim0), rtab);
    r1     = resp(1, mode, int'(stim1), rtab);
    if (sel == 0) begin
      o_stim = int'(stim0); o_err = int'(err0); o_fe = int'(fe0);
      o_busy = busy0; o_done = done0; o_pass = pass0;
    end else begin
      o_stim = int'(stim1); o_err = int'(err1); o_fe = int'(fe1);
      o_busy = busy1; o_done = done1; o_pass = pass1;
    end
  end

  truth_table_checker #(.N_IN(2), .TRUTH(GOLD0), .SETTLE(S0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .stim(stim0), .dut_r(r0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_vec(fe0)
  );

  truth_table_checker #(.N_IN(3), .TRUTH(GOLD1), .SETTLE(S1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stim(stim1), .dut_r(r1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_vec(fe1)
  );

  task automatic check_zero(input string tag);
    nvec++;
    if ((o_stim !== 0) || (o_err !== 0) || (o_fe !== 0) ||
        (o_busy !== 1'b0) || (o_done !== 1'b0) || (o_pass !== 1'b0)) begin
      nerr++;
      $display("FAIL %s inst%0d: stim=%0d err=%0d fe=%0d busy=%b done=%b pass=%b, required all 0",
               tag, sel, o_stim, o_err, o_fe, o_busy, o_done, o_pass);
    end
  endtask

  // One sweep on instance inst. If hold is set, start stays high until just
  // before done. Every cycle is checked against the arithmetic timeline.
  task automatic run_sweep(input int inst, input bit hold, input string tag);
    int n, s, gold, errs, first, t_done, fin_stim;
    int e_stim, e_err, e_fe;
    bit e_busy, e_done;
    logic v;
    n = (inst != 0) ? 8 : 4;
    s = (inst != 0) ? S1 : S0;
    gold = (inst != 0) ? int'(GOLD1) : int'(GOLD0);
    errs = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      v = resp(inst, mode, k, rtab);
      if (v !== gold[k]) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    if (STOP && errs > 0) begin
      t_done = (first + 1) * (s + 1);
      fin_stim = first;
    end else begin
      t_done = n * (s + 1);
      fin_stim = n - 1;
    end

    sel = inst;
    @(negedge clk);
    start_q = 1'b1;
    for (int e = 0; e <= t_done + 3; e++) begin
      @(negedge clk);
      if (!hold || e >= t_done - 1) start_q = 1'b0;
      e_busy = (e < t_done);
      e_done = (e >= t_done);
      e_stim = e_busy ? ((e / (s + 1) > n - 1) ? n - 1 : e / (s + 1)) : fin_stim;
      // Mismatches whose sample edge (k+1)*(s+1) has already passed.
      e_err = 0;
      e_fe = 0;
      for (int k = 0; k < n; k++) begin
        v = resp(inst, mode, k, rtab);
        if ((v !== gold[k]) && ((k + 1) * (s + 1) <= e) && !(STOP && e_err > 0)) begin
          if (e_err == 0) e_fe = k;
          e_err++;
        end
      end
      nvec++;
      if ((o_stim !== e_stim) || (o_busy !== e_busy) || (o_done !== e_done) ||
          (o_err !== e_err) || (o_pass !== (e_done && e_err == 0)) ||
          ((e_err != 0) && (o_fe !== e_fe))) begin
        nerr++;
        $display("FAIL %s inst%0d edge%0d: stim=%0d busy=%b done=%b err=%0d fe=%0d pass=%b, required stim=%0d busy=%b done=%b err=%0d fe=%0d pass=%b",
                 tag, inst, e, o_stim, o_busy, o_done, o_err, o_fe, o_pass,
                 e_stim, e_busy, e_done, e_err, e_fe, (e_done && e_err == 0));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    sel = 0; check_zero("reset_state");
    sel = 1; check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_nand();
    mode = 0; run_sweep(0, 1'b0, "nand_ok");
    mode = 1; run_sweep(0, 1'b0, "tied_one");
    mode = 2; run_sweep(0, 1'b0, "and_dut");
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    sel = 0;
    mode = STOP ? 1 : 2;
    @(negedge clk);
    start_q = 1'b1;
    @(negedge clk);
    start_q = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (o_stim == 2) found = 1'b1;
      else @(negedge clk);
    end
    nvec++;
    if (!found) begin
      nerr++;
      $display("FAIL async_reset_wait: stim never reached 2, required 2 within 40 cycles");
    end
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    run_sweep(0, 1'b0, "after_reset");
  endtask

  task automatic test_retrigger();
    mode = 0; run_sweep(0, 1'b1, "start_held");
    run_sweep(0, 1'b0, "fin_retrig");
    mode = 2; run_sweep(0, 1'b1, "start_held_err");
    run_sweep(0, 1'b0, "fin_retrig_err");
  endtask

  task automatic test_xor3();
    mode = 0; run_sweep(1, 1'b0, "xor3_ok");
    mode = 2; run_sweep(1, 1'b0, "xor3_inv");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      mode = 3;
      rtab = int'($urandom_range(0, 255));
      run_sweep(i % 2, 1'b0, "random_tab");
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    start_q = 1'b0;
    sel = 0;
    mode = 0;
    rtab = 0;
    test_reset();
    test_nand();
    test_async_reset();
    test_retrigger();
    test_xor3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
